// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file: read ports,
// destination reservation, writeback and pending-count status.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_valid;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ready;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output rd_addr, rsv_valid, rsv_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, rsv_ready, pend_cnt
  );

  modport slave (
    input  rd_addr, rsv_valid, rsv_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, rsv_ready, pend_cnt
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register pending-write scoreboard.
// Define RF_BYPASS_EN for same-cycle writeback-to-read forwarding.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned NRD   = NUM_RD;

  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         pend;
  logic [ADDR_W:0]          cnt;
  logic                     wr_eff;
  logic                     rsv_zero;
  logic                     rsv_ok;
  logic                     rsv_acc;
  logic                     inc;
  logic                     dec;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  always_comb begin
    wr_eff   = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
    rsv_zero = (ZERO_REG != 0) && (bus.rsv_addr == '0);
    rsv_ok   = bus.rsv_valid &&
               (rsv_zero || !pend[bus.rsv_addr] ||
                (bus.wr_en && (bus.wr_addr == bus.rsv_addr)));
    rsv_acc  = rsv_ok && !rsv_zero;
    inc      = rsv_acc && !pend[bus.rsv_addr];
    // A write whose bit is immediately re-reserved leaves the count unchanged
    dec      = wr_eff && pend[bus.wr_addr] &&
               !(rsv_acc && (bus.rsv_addr == bus.wr_addr));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs[r[ADDR_W-1:0]] <= '0;
      end
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (wr_eff) begin
        regs[bus.wr_addr] <= bus.wr_data;
        pend[bus.wr_addr] <= 1'b0;
      end
      // Later assignment wins, so reserve overrides a same-address write clear
      if (rsv_acc) begin
        pend[bus.rsv_addr] <= 1'b1;
      end
      case ({inc, dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_comb begin : read_ports
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a = bus.rd_addr[i*ADDR_W +: ADDR_W];
      d = regs[a];
      b = pend[a];
`ifdef RF_BYPASS_EN
      if (wr_eff && (bus.wr_addr == a)) begin
        d = bus.wr_data;
        b = 1'b0;
      end
`endif
      if (!reset_n || ((ZERO_REG != 0) && (a == '0))) begin
        d = '0;
        b = 1'b0;
      end
      rd_data_c[i*DATA_W +: DATA_W] = d;
      rd_busy_c[i]                  = b;
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_busy   = rd_busy_c;
  assign bus.rsv_ready = reset_n && rsv_ok;
  assign bus.pend_cnt  = cnt;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// against an array-based reference model.
module tb_regfile_mp;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_RD   = 2;
  localparam int ZERO_REG = 1;
  localparam int DEPTH    = 2**ADDR_W;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_pend [DEPTH];
  int errors = 0;
  int checks = 0;

  function automatic bit is_zero(input int a);
    return (ZERO_REG != 0) && (a == 0);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int a);
    if (!reset_n || is_zero(a)) return '0;
`ifdef RF_BYPASS_EN
    if (bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (!reset_n || is_zero(a)) return 1'b0;
`ifdef RF_BYPASS_EN
    if (bus.wr_en && int'(bus.wr_addr) == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  function automatic logic exp_ready();
    int a;
    a = int'(bus.rsv_addr);
    if (!reset_n || !bus.rsv_valid) return 1'b0;
    if (is_zero(a)) return 1'b1;
    return !m_pend[a] || (bus.wr_en && int'(bus.wr_addr) == a);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int r = 0; r < DEPTH; r++) n += int'(m_pend[r]);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rv, input int ra, input logic we, input int wa,
                       input logic [DATA_W-1:0] wd, input int r0, input int r1);
    bus.rsv_valid = rv;
    bus.rsv_addr  = ADDR_W'(ra);
    bus.wr_en     = we;
    bus.wr_addr   = ADDR_W'(wa);
    bus.wr_data   = wd;
    bus.rd_addr   = {ADDR_W'(r1), ADDR_W'(r0)};
  endtask

  task automatic tick(input string tag);
    logic rdy;
    #1;
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("%s/rd_data%0d", tag, p), 64'(bus.rd_data[p*DATA_W +: DATA_W]),
          64'(exp_data(int'(bus.rd_addr[p*ADDR_W +: ADDR_W]))));
      chk($sformatf("%s/rd_busy%0d", tag, p), 64'(bus.rd_busy[p]),
          64'(exp_busy(int'(bus.rd_addr[p*ADDR_W +: ADDR_W]))));
    end
    rdy = exp_ready();
    chk({tag, "/rsv_ready"}, 64'(bus.rsv_ready), 64'(rdy));
    chk({tag, "/pend_cnt"}, 64'(bus.pend_cnt), 64'(exp_cnt()));
    @(posedge clk);
    if (!reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = '0;
        m_pend[r] = 1'b0;
      end
    end else begin
      if (bus.wr_en && !is_zero(int'(bus.wr_addr))) begin
        m_regs[bus.wr_addr] = bus.wr_data;
        m_pend[bus.wr_addr] = 1'b0;
      end
      if (rdy && !is_zero(int'(bus.rsv_addr))) m_pend[bus.rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic rand_drive(input int amax);
    drive(1'($urandom_range(0, 1)), int'($urandom_range(0, amax)),
          1'($urandom_range(0, 1)), int'($urandom_range(0, amax)), $urandom,
          int'($urandom_range(0, amax)), int'($urandom_range(0, amax)));
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
    reset_n = 1'b0;
    drive(1'b0, 0, 1'b0, 0, '0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    tick("reset");
    reset_n = 1'b1;

    // 1: random traffic, then reset with a write presented
    for (int n = 0; n < 20; n++) begin
      rand_drive(DEPTH - 1);
      tick("t1_rand");
    end
    reset_n = 1'b0;
    drive(1'b1, 9, 1'b1, 4, 32'hCAFE_0001, 4, 9);
    tick("t1_rst");
    reset_n = 1'b1;
    drive(1'b0, 0, 1'b0, 0, '0, 4, 9);
    #1;
    chk("t1_data0", 64'(bus.rd_data[31:0]), 64'h0);
    chk("t1_busy", 64'(bus.rd_busy), 64'h0);
    chk("t1_cnt", 64'(bus.pend_cnt), 64'h0);
    tick("t1_post");

    // 2: reserve r5, observe busy, write it back
    drive(1'b1, 5, 1'b0, 0, '0, 5, 5);
    tick("t2_rsv");
    drive(1'b0, 0, 1'b0, 0, '0, 5, 5);
    #1;
    chk("t2_busy", 64'(bus.rd_busy), 64'h3);
    chk("t2_cnt", 64'(bus.pend_cnt), 64'h1);
    tick("t2_hold");
    drive(1'b0, 0, 1'b1, 5, 32'hDEAD_BEEF, 5, 5);
    tick("t2_wr");
    drive(1'b0, 0, 1'b0, 0, '0, 5, 5);
    #1;
    chk("t2_data", 64'(bus.rd_data[DATA_W +: DATA_W]), 64'hDEAD_BEEF);
    chk("t2_cnt0", 64'(bus.pend_cnt), 64'h0);
    tick("t2_after");

    // 3: WAW stall and same-cycle retire + reserve on r7
    drive(1'b1, 7, 1'b0, 0, '0, 7, 7);
    tick("t3_rsv");
    drive(1'b1, 7, 1'b0, 0, '0, 7, 7);
    #1 chk("t3_stall", 64'(bus.rsv_ready), 64'h0);
    tick("t3_stall");
    drive(1'b1, 7, 1'b1, 7, 32'h11, 7, 7);
    #1 chk("t3_accept", 64'(bus.rsv_ready), 64'h1);
    tick("t3_both");
    drive(1'b0, 0, 1'b0, 0, '0, 7, 7);
    #1;
    chk("t3_busy", 64'(bus.rd_busy), 64'h3);
    chk("t3_data", 64'(bus.rd_data[31:0]), 64'h11);
    chk("t3_cnt", 64'(bus.pend_cnt), 64'h1);
    tick("t3_after");
    drive(1'b0, 0, 1'b1, 7, 32'h22, 7, 0);
    tick("t3_clear");

    // 4: zero register ignores writes and reservations
    drive(1'b1, 0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0);
    #1 chk("t4_ready", 64'(bus.rsv_ready), 64'h1);
    tick("t4_wr0");
    drive(1'b0, 0, 1'b0, 0, '0, 0, 0);
    #1;
    chk("t4_data", 64'(bus.rd_data), 64'h0);
    chk("t4_busy", 64'(bus.rd_busy), 64'h0);
    chk("t4_cnt", 64'(bus.pend_cnt), 64'h0);
    tick("t4_after");

    // 5: write while both ports read the same register
    drive(1'b0, 0, 1'b1, 3, 32'hAAAA, 0, 0);
    tick("t5_init");
    drive(1'b0, 0, 1'b1, 3, 32'h1234, 3, 3);
`ifdef RF_BYPASS_EN
    #1 chk("t5_same", 64'(bus.rd_data), 64'h0000_1234_0000_1234);
`else
    #1 chk("t5_same", 64'(bus.rd_data), 64'h0000_AAAA_0000_AAAA);
`endif
    tick("t5_wr");
    drive(1'b0, 0, 1'b0, 0, '0, 3, 3);
    #1 chk("t5_next", 64'(bus.rd_data), 64'h0000_1234_0000_1234);
    tick("t5_after");

    // 6: fill the scoreboard, then reset mid-sequence
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, a, 1'b0, 0, '0, a, (a + 1) % DEPTH);
      tick("t6_fill");
    end
    drive(1'b1, 1, 1'b0, 0, '0, 1, 31);
    #1;
    chk("t6_full", 64'(bus.pend_cnt), 64'(DEPTH - ZERO_REG));
    chk("t6_stall", 64'(bus.rsv_ready), 64'h0);
    tick("t6_full");
    reset_n = 1'b0;
    drive(1'b0, 0, 1'b1, 2, 32'h55, 2, 3);
    tick("t6_rst");
    reset_n = 1'b1;
    drive(1'b0, 0, 1'b0, 0, '0, 2, 3);
    #1 chk("t6_cnt0", 64'(bus.pend_cnt), 64'h0);
    tick("t6_after");

    // Random traffic on a narrow address window to provoke collisions
    for (int n = 0; n < 300; n++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      rand_drive((n % 3 == 0) ? DEPTH - 1 : 7);
      tick("rand");
    end
    reset_n = 1'b1;
    drive(1'b0, 0, 1'b0, 0, '0, 0, 0);
    tick("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
